alu_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the registered ALU. Per instruction it fetches a 32-bit word from instruction memory, decodes the register indices and immediate, and issues a one-cycle ALU enable. It then routes the result to register-file writeback, a data-memory access or a PC redirect. It sits between instruction memory, the register file, the ALU and data memory, and owns the PC.

---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_sequencer_imm_gen.sv | 28 ++
 rtl/alu_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// alu_seq_pkg: opcode constants, sequencer state encoding and instruction legality check.
package alu_seq_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WAIT   = 3'd4,
      S_MEM    = 3'd5,
      S_WB     = 3'd6,
      S_TRAP   = 3'd7
   } state_t;

   // Unknown opcodes are illegal regardless of funct3; branches accept any funct3.
   function automatic logic instr_legal(input logic [6:0] op, input logic [2:0] funct3);
      logic ok;
      case (op)
         OP_R, OP_I: ok = (funct3 < 3'd6);
         OP_LOAD:    ok = (funct3 == 3'b001);
         OP_STORE:   ok = (funct3 == 3'b000);
         OP_BRANCH:  ok = 1'b1;
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_imm_gen.sv
`default_nettype none
// imm_gen: combinational immediate extraction and sign extension selected by opcode.
module imm_gen
   import alu_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [6:0]      op,
   input  logic [11:0]     hi,   // instruction bits [31:20]
   input  logic [4:0]      lo,   // instruction bits [11:7]
   output logic [XLEN-1:0] imm
);

   logic [12:0] raw;

   always_comb begin
      raw = '0;
      case (op)
         OP_I, OP_LOAD: raw = {hi[11], hi};
         OP_STORE:      raw = {hi[11], hi[11:5], lo};
         OP_BRANCH:     raw = {hi[11], lo[0], hi[10:5], lo[4:1], 1'b0};
         default:       raw = '0;
      endcase
      imm = {{(XLEN-13){raw[12]}}, raw};
   end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// alu_sequencer: multi-cycle fetch/decode/execute control FSM for the registered ALU.
// Owns the PC and routes each result to writeback, data memory or a PC redirect.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int                XLEN     = 32,
   parameter int                ADDR_W   = 12,
   parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
   input  logic              clk,
   input  logic              I_rst_n,
   input  logic              I_run,
   output logic              O_imem_req,
   output logic [ADDR_W-1:0] O_imem_addr,
   input  logic              I_imem_ack,
   input  logic [XLEN-1:0]   I_imem_data,
   output logic [4:0]        O_rs1,
   output logic [4:0]        O_rs2,
   output logic [4:0]        O_rd,
   output logic              O_rf_we,
   output logic              O_alu_en,
   output logic [6:0]        O_alu_op,
   output logic [2:0]        O_alu_funct3,
   output logic [6:0]        O_alu_funct7,
   output logic [XLEN-1:0]   O_alu_imm,
   input  logic [ADDR_W-1:0] I_alu_addr,
   input  logic              I_alu_read2,
   output logic              O_dmem_req,
   output logic              O_dmem_we,
   input  logic              I_dmem_ack,
   output logic [ADDR_W-1:0] O_pc,
   output logic              O_busy,
   output logic              O_illegal
);

   state_t            state, state_nx, after_state;
   logic [ADDR_W-1:0] pc, pc_nx, pc_inc;
   logic [31:0]       instr;
   logic              illegal;
   logic [6:0]        op;
   logic              legal;

   assign op          = instr[6:0];
   assign legal       = instr_legal(op, instr[14:12]);
   assign pc_inc      = pc + ADDR_W'(4);
   assign after_state = I_run ? S_FETCH : S_IDLE;

   // Decode fields come straight from the latched word, so they hold steady until the next fetch.
   assign O_rs1        = instr[19:15];
   assign O_rs2        = instr[24:20];
   assign O_rd         = instr[11:7];
   assign O_alu_op     = op;
   assign O_alu_funct3 = instr[14:12];
   assign O_alu_funct7 = instr[31:25];
   assign O_imem_addr  = pc;
   assign O_pc         = pc;
   assign O_illegal    = illegal;
   assign O_busy       = (state != S_IDLE) && (state != S_TRAP);

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .op  (op),
      .hi  (instr[31:20]),
      .lo  (instr[11:7]),
      .imm (O_alu_imm)
   );

   always_ff @(posedge clk) begin
      if (!I_rst_n) begin
         state   <= S_IDLE;
         pc      <= PC_RESET;
         instr   <= '0;
         illegal <= 1'b0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         if (state == S_FETCH && I_imem_ack)
            instr <= I_imem_data[31:0];
         if (state == S_DECODE && !legal)
            illegal <= 1'b1;
      end
   end

   always_comb begin
      state_nx   = state;
      pc_nx      = pc;
      O_imem_req = 1'b0;
      O_alu_en   = 1'b0;
      O_rf_we    = 1'b0;
      O_dmem_req = 1'b0;
      O_dmem_we  = 1'b0;
      case (state)
         S_IDLE:   if (I_run) state_nx = S_FETCH;
         S_FETCH: begin
            O_imem_req = 1'b1;
            if (I_imem_ack) state_nx = S_DECODE;
         end
         S_DECODE: state_nx = legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            O_alu_en = 1'b1;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            case (op)
               OP_R, OP_I:        state_nx = S_WB;
               OP_LOAD, OP_STORE: state_nx = S_MEM;
               OP_BRANCH: begin
                  pc_nx    = I_alu_addr;
                  state_nx = after_state;
               end
               default:           state_nx = S_TRAP;
            endcase
         end
         S_MEM: begin
            O_dmem_req = 1'b1;
            O_dmem_we  = I_alu_read2;
            if (I_dmem_ack) begin
               if (op == OP_LOAD) begin
                  state_nx = S_WB;
               end else begin
                  pc_nx    = pc_inc;
                  state_nx = after_state;
               end
            end
         end
         S_WB: begin
            O_rf_we  = (instr[11:7] != 5'd0);
            pc_nx    = pc_inc;
            state_nx = after_state;
         end
         S_TRAP:   state_nx = S_TRAP;
         default:  state_nx = S_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// tb_alu_sequencer: directed and randomized checks of the sequencer against a behavioural model.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, run, imem_ack, dmem_ack, alu_read2;
   logic [31:0] imem_data;
   logic [11:0] alu_addr;
   logic        imem_req, rf_we, alu_en, dmem_req, dmem_we, busy, illegal;
   logic [11:0] imem_addr, pc;
   logic [4:0]  rs1, rs2, rd;
   logic [6:0]  alu_op, alu_f7;
   logic [2:0]  alu_f3;
   logic [31:0] imm;

   int errors = 0;
   int checks = 0;

   alu_sequencer #(.XLEN(32), .ADDR_W(12), .PC_RESET(12'h000)) dut (
      .clk(clk), .I_rst_n(rst_n), .I_run(run),
      .O_imem_req(imem_req), .O_imem_addr(imem_addr), .I_imem_ack(imem_ack), .I_imem_data(imem_data),
      .O_rs1(rs1), .O_rs2(rs2), .O_rd(rd), .O_rf_we(rf_we), .O_alu_en(alu_en),
      .O_alu_op(alu_op), .O_alu_funct3(alu_f3), .O_alu_funct7(alu_f7), .O_alu_imm(imm),
      .I_alu_addr(alu_addr), .I_alu_read2(alu_read2),
      .O_dmem_req(dmem_req), .O_dmem_we(dmem_we), .I_dmem_ack(dmem_ack),
      .O_pc(pc), .O_busy(busy), .O_illegal(illegal)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] ADD   = 32'h002081B3;  // add x3,x1,x2
   localparam logic [31:0] LOAD  = 32'h00409103;  // load funct3=001, rd=2, imm=4
   localparam logic [31:0] STORE = 32'h00208223;  // store funct3=000, imm=4
   localparam logic [31:0] BEQ   = 32'h00208463;

   typedef struct {
      bit          legal;
      int          cycles;
      int          alu_at;
      int          wb_n;
      int          mem_n;
      logic [11:0] pc;
      logic [31:0] imm;
   } exp_t;

   // Observations from the last drive_instr call
   int          obs_cycles, obs_alu_n, obs_alu_at, obs_wb_n, obs_mem_n;
   logic [4:0]  obs_wb_rd;
   logic        obs_mem_we, obs_stable;
   logic [63:0] obs_ctl;
   logic [11:0] obs_faddr;

   function automatic exp_t model(input logic [31:0] ins, input int di, input int dd,
                                  input logic [11:0] pc0, input logic [11:0] tgt);
      exp_t e;
      logic [6:0] op;
      int f3, rdv, sx, mid;
      bit is_ri, is_ld, is_st, is_br;
      op = ins[6:0];
      f3 = int'(ins[14:12]);
      rdv = int'(ins[11:7]);
      is_ri = (op == 7'h33) || (op == 7'h13);
      is_ld = (op == 7'h03);
      is_st = (op == 7'h23);
      is_br = (op == 7'h63);
      e.legal = (is_ri && f3 <= 5) || (is_ld && f3 == 1) || (is_st && f3 == 0) || is_br;
      if (!e.legal)  e.cycles = 2 + di;
      else if (is_ri) e.cycles = 5 + di;
      else if (is_br) e.cycles = 4 + di;
      else if (is_st) e.cycles = 5 + di + dd;
      else            e.cycles = 6 + di + dd;
      e.alu_at = e.legal ? 3 + di : 0;
      e.wb_n   = (e.legal && (is_ri || is_ld) && rdv != 0) ? 1 : 0;
      e.mem_n  = (e.legal && (is_ld || is_st)) ? 1 + dd : 0;
      e.pc     = !e.legal ? pc0 : (is_br ? tgt : pc0 + 12'd4);
      sx = ins;
      if (op == 7'h13 || is_ld) begin
         mid = sx >>> 20;
         e.imm = mid;
      end else if (is_st) begin
         mid = sx >>> 25;
         e.imm = mid * 32 + rdv;
      end else if (is_br) begin
         mid = sx >>> 31;
         e.imm = mid * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      end else begin
         e.imm = 32'h0;
      end
      return e;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      alu_read2 = 1'b0; imem_data = '0; alu_addr = '0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Runs one instruction from IDLE with I_run dropped after fetch starts; records what the DUT did.
   task automatic drive_instr(input logic [31:0] ins, input int di, input int dd,
                              input logic [11:0] tgt, input logic rd2);
      int iw, dw;
      logic [63:0] ctl_h [0:47];
      iw = di; dw = dd;
      obs_cycles = -1; obs_alu_n = 0; obs_alu_at = 0; obs_wb_n = 0; obs_mem_n = 0;
      obs_wb_rd = '0; obs_mem_we = 1'b0; obs_stable = 1'b0; obs_ctl = '0; obs_faddr = '0;
      imem_data = ins; alu_addr = tgt; alu_read2 = rd2;
      run = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         imem_ack = imem_req && (iw == 0);
         dmem_ack = dmem_req && (dw == 0);
         @(negedge clk);
         if (c == 1) obs_faddr = imem_addr;
         ctl_h[c] = {alu_op, alu_f3, alu_f7, imm, rs1, rs2, rd};
         if (alu_en) begin obs_alu_n++; obs_alu_at = c; end
         if (rf_we) begin obs_wb_n++; obs_wb_rd = rd; end
         if (dmem_req) begin obs_mem_n++; obs_mem_we = obs_mem_we | dmem_we; end
         if (imem_req && iw > 0) iw--;
         if (dmem_req && dw > 0) dw--;
         @(posedge clk); #1;
         if (!busy) begin obs_cycles = c; break; end
      end
      imem_ack = 1'b0; dmem_ack = 1'b0;
      if (obs_alu_at > 1 && obs_alu_at < 40) begin
         obs_ctl    = ctl_h[obs_alu_at];
         obs_stable = (ctl_h[obs_alu_at-1] == obs_ctl) && (ctl_h[obs_alu_at+1] == obs_ctl);
      end
   endtask

   task automatic test_reset();
      do_reset();
      drive_instr(LOAD, 0, 0, 12'h0, 1'b0);
      do_reset();
      @(negedge clk);
      checks++; if (busy !== 1'b0 || illegal !== 1'b0) begin errors++;
         $display("FAIL reset_flags: got busy=%b illegal=%b expected 0/0", busy, illegal); end
      checks++; if (pc !== 12'h000 || imem_addr !== 12'h000) begin errors++;
         $display("FAIL reset_pc: got pc=%h addr=%h expected 000", pc, imem_addr); end
      checks++; if ({imem_req, alu_en, rf_we, dmem_req, dmem_we} !== 5'b0) begin errors++;
         $display("FAIL reset_strobes: got %b expected 00000", {imem_req, alu_en, rf_we, dmem_req, dmem_we}); end
      checks++; if ({rs1, rs2, rd, alu_op, alu_f3, alu_f7, imm} !== 64'h0) begin errors++;
         $display("FAIL reset_fields: got %h expected 0", {rs1, rs2, rd, alu_op, alu_f3, alu_f7, imm}); end
      @(posedge clk); #1;
   endtask

   task automatic test_r_add();
      do_reset();
      drive_instr(ADD, 0, 0, 12'h0, 1'b0);
      checks++; if (obs_alu_at !== 3 || obs_alu_n !== 1) begin errors++;
         $display("FAIL radd_alu_en: got cycle %0d count %0d expected cycle 3 count 1", obs_alu_at, obs_alu_n); end
      checks++; if (obs_wb_n !== 1 || obs_wb_rd !== 5'd3) begin errors++;
         $display("FAIL radd_wb: got count %0d rd %0d expected 1 rd 3", obs_wb_n, obs_wb_rd); end
      checks++; if (obs_cycles !== 5 || pc !== 12'h004) begin errors++;
         $display("FAIL radd_done: got cycles %0d pc %h expected 5 004", obs_cycles, pc); end
   endtask

   task automatic test_load();
      drive_instr(LOAD, 0, 2, 12'h0, 1'b0);
      checks++; if (obs_mem_n !== 3 || obs_mem_we !== 1'b0) begin errors++;
         $display("FAIL load_mem: got req cycles %0d we %b expected 3 0", obs_mem_n, obs_mem_we); end
      checks++; if (obs_wb_n !== 1 || obs_wb_rd !== 5'd2) begin errors++;
         $display("FAIL load_wb: got count %0d rd %0d expected 1 rd 2", obs_wb_n, obs_wb_rd); end
      checks++; if (obs_cycles !== 8 || pc !== 12'h008) begin errors++;
         $display("FAIL load_done: got cycles %0d pc %h expected 8 008", obs_cycles, pc); end
      checks++; if (obs_ctl[31+15:15] !== 32'd4) begin errors++;
         $display("FAIL load_imm: got %h expected 00000004", obs_ctl[31+15:15]); end
   endtask

   task automatic test_store();
      drive_instr(STORE, 0, 0, 12'h0, 1'b1);
      checks++; if (obs_mem_we !== 1'b1 || obs_wb_n !== 0) begin errors++;
         $display("FAIL store_mem: got we %b wb %0d expected 1 0", obs_mem_we, obs_wb_n); end
      checks++; if (obs_cycles !== 5 || pc !== 12'h00C) begin errors++;
         $display("FAIL store_done: got cycles %0d pc %h expected 5 00c", obs_cycles, pc); end
   endtask

   task automatic test_branch_wrap();
      drive_instr(BEQ, 0, 0, 12'h040, 1'b0);
      checks++; if (obs_cycles !== 4 || pc !== 12'h040) begin errors++;
         $display("FAIL branch: got cycles %0d pc %h expected 4 040", obs_cycles, pc); end
      drive_instr(BEQ, 0, 0, 12'hFFC, 1'b0);
      drive_instr(ADD, 0, 0, 12'h0, 1'b0);
      checks++; if (obs_faddr !== 12'hFFC || pc !== 12'h000) begin errors++;
         $display("FAIL pc_wrap: got fetch %h pc %h expected ffc 000", obs_faddr, pc); end
   endtask

   task automatic test_illegal();
      do_reset();
      drive_instr(32'h0000007F, 0, 0, 12'h0, 1'b0);
      checks++; if (obs_cycles !== 2 || illegal !== 1'b1 || obs_alu_n !== 0) begin errors++;
         $display("FAIL trap_op: got cycles %0d illegal %b alu %0d expected 2 1 0", obs_cycles, illegal, obs_alu_n); end
      run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (illegal !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0) begin errors++;
            $display("FAIL trap_hold: got illegal %b busy %b req %b expected 1 0 0", illegal, busy, imem_req); end
      end
      do_reset();
      @(negedge clk);
      checks++; if (illegal !== 1'b0) begin errors++;
         $display("FAIL trap_clear: got %b expected 0", illegal); end
      @(posedge clk); #1;
      drive_instr(32'h0020E1B3, 0, 0, 12'h0, 1'b0);
      checks++; if (illegal !== 1'b1 || busy !== 1'b0 || pc !== 12'h000) begin errors++;
         $display("FAIL trap_f3: got illegal %b busy %b pc %h expected 1 0 000", illegal, busy, pc); end
   endtask

   task automatic test_reset_mid_mem();
      int seen;
      do_reset();
      drive_instr(ADD, 0, 0, 12'h0, 1'b0);
      imem_data = LOAD; run = 1'b1; seen = 0;
      @(posedge clk); #1;
      for (int c = 0; c < 20 && seen < 2; c++) begin
         imem_ack = imem_req; dmem_ack = 1'b0;
         if (dmem_req) seen++;
         if (seen < 2) begin @(posedge clk); #1; end
      end
      checks++; if (seen !== 2) begin errors++;
         $display("FAIL rstmem_reach: got %0d mem cycles expected 2", seen); end
      rst_n = 1'b0; imem_ack = 1'b0; run = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++; if (busy !== 1'b0 || dmem_req !== 1'b0 || pc !== 12'h000) begin errors++;
         $display("FAIL rstmem_state: got busy %b req %b pc %h expected 0 0 000", busy, dmem_req, pc); end
      rst_n = 1'b1; dmem_ack = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++; if (busy !== 1'b0 || rf_we !== 1'b0 || dmem_req !== 1'b0 || pc !== 12'h000) begin errors++;
         $display("FAIL rstmem_late_ack: got busy %b we %b req %b pc %h expected 0 0 0 000", busy, rf_we, dmem_req, pc); end
      dmem_ack = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int f2, done;
      do_reset();
      f2 = -1; done = -1; alu_addr = 12'h080;
      run = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 30; c++) begin
         imem_data = (imem_addr == 12'h000) ? ADD : BEQ;
         imem_ack  = imem_req;
         if (imem_req && imem_addr == 12'h004 && f2 < 0) begin f2 = c; run = 1'b0; end
         @(posedge clk); #1;
         if (!busy) begin done = c; break; end
      end
      imem_ack = 1'b0; run = 1'b0;
      checks++; if (f2 !== 6) begin errors++;
         $display("FAIL b2b_fetch2: got cycle %0d expected 6", f2); end
      checks++; if (done !== 9 || pc !== 12'h080) begin errors++;
         $display("FAIL b2b_done: got cycle %0d pc %h expected 9 080", done, pc); end
   endtask

   task automatic test_random(input int n);
      logic [31:0] ins;
      logic [11:0] pcm, tgt;
      logic [63:0] ctl_exp;
      int sel, di, dd;
      exp_t e;
      do_reset();
      pcm = 12'h000;
      for (int k = 0; k < n; k++) begin
         ins = $urandom;
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1: begin ins[6:0] = 7'h33; ins[14:12] = 3'($urandom_range(0, 5)); end
            2, 3: begin ins[6:0] = 7'h13; ins[14:12] = 3'($urandom_range(0, 5)); end
            4:    begin ins[6:0] = 7'h03; ins[14:12] = 3'd1; end
            5:    begin ins[6:0] = 7'h23; ins[14:12] = 3'd0; end
            6, 7: ins[6:0] = 7'h63;
            8:    ;
            default: ins[6:0] = 7'h33;
         endcase
         tgt = 12'($urandom);
         di  = $urandom_range(0, 2);
         dd  = $urandom_range(0, 3);
         e   = model(ins, di, dd, pcm, tgt);
         drive_instr(ins, di, dd, tgt, ins[6:0] == 7'h23);
         ctl_exp = {ins[6:0], ins[14:12], ins[31:25], e.imm, ins[19:15], ins[24:20], ins[11:7]};
         checks++; if (obs_faddr !== pcm || obs_cycles !== e.cycles) begin errors++;
            $display("FAIL rnd%0d_fetch: ins %h got addr %h cycles %0d expected %h %0d", k, ins, obs_faddr, obs_cycles, pcm, e.cycles); end
         checks++; if (obs_alu_at !== e.alu_at || obs_wb_n !== e.wb_n || obs_mem_n !== e.mem_n) begin errors++;
            $display("FAIL rnd%0d_strobes: ins %h got alu@%0d wb %0d mem %0d expected %0d %0d %0d", k, ins, obs_alu_at, obs_wb_n, obs_mem_n, e.alu_at, e.wb_n, e.mem_n); end
         checks++; if (pc !== e.pc || illegal !== !e.legal) begin errors++;
            $display("FAIL rnd%0d_pc: ins %h got pc %h illegal %b expected %h %b", k, ins, pc, illegal, e.pc, !e.legal); end
         if (e.legal) begin
            checks++; if (obs_ctl !== ctl_exp || obs_stable !== 1'b1) begin errors++;
               $display("FAIL rnd%0d_ctl: ins %h got %h stable %b expected %h 1", k, ins, obs_ctl, obs_stable, ctl_exp); end
         end
         if (e.wb_n == 1) begin
            checks++; if (obs_wb_rd !== ins[11:7]) begin errors++;
               $display("FAIL rnd%0d_rd: got %0d expected %0d", k, obs_wb_rd, ins[11:7]); end
         end
         if (e.mem_n > 0) begin
            checks++; if (obs_mem_we !== (ins[6:0] == 7'h23)) begin errors++;
               $display("FAIL rnd%0d_we: got %b expected %b", k, obs_mem_we, ins[6:0] == 7'h23); end
         end
         if (!e.legal) begin
            do_reset();
            pcm = 12'h000;
         end else begin
            pcm = e.pc;
         end
      end
   endtask

   initial begin
      test_reset();
      test_r_add();
      test_load();
      test_store();
      test_branch_wrap();
      test_illegal();
      test_reset_mid_mem();
      test_back_to_back();
      test_random(60);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
